check_multi: RTL and testbench

//  Next-generation result checker. Pops one captured result vector (RES_FIFO) and one

---
 rtl/check_multi.sv | 155 +++++++++++++++
 tb/tb_check_multi.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/check_multi.sv
// Result checker: pops one result vector and one check record, masks and compares
// them, and writes an NWORDS-word result record to memory over an Avalon-MM master.
module check_multi #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int RTF_WIDTH  = 24,
  parameter int CHF_WIDTH  = RTF_WIDTH + ADDR_WIDTH,
  parameter int SCC_WIDTH  = 5,
  parameter int SCD_WIDTH  = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH/8-1:0] mem_byteenable,
  output logic                    mem_write,
  output logic [DATA_WIDTH-1:0]   mem_writedata,
  input  logic                    mem_waitrequest,
  input  logic [RTF_WIDTH-1:0]    rfifo_data,
  output logic                    rfifo_rdreq,
  input  logic                    rfifo_rdempty,
  input  logic [CHF_WIDTH-1:0]    cfifo_data,
  output logic                    cfifo_rdreq,
  input  logic                    cfifo_rdempty,
  input  logic [SCC_WIDTH-1:0]    sc_cmd,
  input  logic [SCD_WIDTH-1:0]    sc_data,
  output logic                    sc_ready,
  output logic [CNT_WIDTH-1:0]    pass_count,
  output logic [CNT_WIDTH-1:0]    fail_count
);

  localparam int NWORDS = (RTF_WIDTH + 8 + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int RECW   = NWORDS * DATA_WIDTH;
  localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  localparam logic [SCC_WIDTH-1:0] CMD_BITMASK   = SCC_WIDTH'(1);
  localparam logic [SCC_WIDTH-1:0] CMD_MODE      = SCC_WIDTH'(2);
  localparam logic [SCC_WIDTH-1:0] CMD_CLR_STATS = SCC_WIDTH'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_FIFOS,
    S_CMP,
    S_WRITEBACK
  } state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [RTF_WIDTH-1:0]   mask_q;
  logic                   fail_only_q;
  logic [CNT_WIDTH-1:0]   pass_q, fail_q;
  logic [RTF_WIDTH-1:0]   res_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   fail_flag_q;

  logic [RTF_WIDTH-1:0]   res_m, exp_m;
  logic                   mismatch;
  logic [RECW-1:0]        rec;
  logic [NWORDS-1:0][DATA_WIDTH-1:0] words;
  logic                   unused_sc;

  assign unused_sc = ^sc_data;

  assign res_m    = rfifo_data & mask_q;
  assign exp_m    = cfifo_data[CHF_WIDTH-1 -: RTF_WIDTH] & mask_q;
  assign mismatch = (res_m != exp_m);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rfifo_rdreq = 1'b0;
    cfifo_rdreq = 1'b0;
    mem_write   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rfifo_rdempty && !cfifo_rdempty) state_d = S_RD_FIFOS;
      end
      S_RD_FIFOS: begin
        rfifo_rdreq = 1'b1;
        cfifo_rdreq = 1'b1;
        state_d     = S_CMP;
      end
      S_CMP: begin
        state_d = (fail_only_q && !mismatch) ? S_IDLE : S_WRITEBACK;
      end
      S_WRITEBACK: begin
        mem_write = 1'b1;
        if (!mem_waitrequest) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Record layout: result in the top bits, metadata byte in the bottom, zero between.
  always_comb begin
    rec                         = '0;
    rec[RECW-1 -: RTF_WIDTH]    = res_q;
    rec[7:0]                    = {1'b1, 6'b0, fail_flag_q};
  end

  assign words          = rec;
  assign mem_writedata  = words[LAST_IDX - idx_q];
  assign mem_address    = addr_q + ADDR_WIDTH'(idx_q);
  assign mem_byteenable = '1;
  assign sc_ready       = (state_q == S_IDLE) && rfifo_rdempty && cfifo_rdempty;
  assign pass_count     = pass_q;
  assign fail_count     = fail_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      mask_q      <= '1;
      fail_only_q <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
      res_q       <= '0;
      addr_q      <= '0;
      fail_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;

      if (sc_cmd == CMD_BITMASK) mask_q      <= sc_data[RTF_WIDTH-1:0];
      if (sc_cmd == CMD_MODE)    fail_only_q <= sc_data[0];

      if (state_q == S_CMP) begin
        res_q       <= res_m;
        addr_q      <= cfifo_data[ADDR_WIDTH-1:0];
        fail_flag_q <= mismatch;
      end

      // A clear coinciding with a compare discards that compare's count.
      if (sc_cmd == CMD_CLR_STATS) begin
        pass_q <= '0;
        fail_q <= '0;
      end else if (state_q == S_CMP) begin
        if (mismatch) begin
          if (fail_q != '1) fail_q <= fail_q + 1'b1;
        end else begin
          if (pass_q != '1) pass_q <= pass_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_check_multi.sv
// Bench for check_multi: FIFO and memory-slave models around a default instance and a
// 2-bit-counter instance, checked against a record-level reference model.
module tb_check_multi;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        mem_waitrequest;
  logic [23:0] rfifo_data;
  logic [43:0] cfifo_data;
  logic        fifo_empty;
  logic [4:0]  sc_cmd;
  logic [23:0] sc_data;

  logic [19:0] a_mem_address, b_mem_address;
  logic [1:0]  a_mem_byteenable, b_mem_byteenable;
  logic        a_mem_write, b_mem_write;
  logic [15:0] a_mem_writedata, b_mem_writedata;
  logic        a_rfifo_rdreq, a_cfifo_rdreq, b_rfifo_rdreq, b_cfifo_rdreq;
  logic        a_sc_ready, b_sc_ready;
  logic [15:0] a_pass_count, a_fail_count;
  logic [1:0]  b_pass_count, b_fail_count;

  always #5 clock = ~clock;

  check_multi dut (
    .clock(clock), .reset_n(reset_n),
    .mem_address(a_mem_address), .mem_byteenable(a_mem_byteenable),
    .mem_write(a_mem_write), .mem_writedata(a_mem_writedata),
    .mem_waitrequest(mem_waitrequest),
    .rfifo_data(rfifo_data), .rfifo_rdreq(a_rfifo_rdreq), .rfifo_rdempty(fifo_empty),
    .cfifo_data(cfifo_data), .cfifo_rdreq(a_cfifo_rdreq), .cfifo_rdempty(fifo_empty),
    .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(a_sc_ready),
    .pass_count(a_pass_count), .fail_count(a_fail_count)
  );

  check_multi #(.CNT_WIDTH(2)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .mem_address(b_mem_address), .mem_byteenable(b_mem_byteenable),
    .mem_write(b_mem_write), .mem_writedata(b_mem_writedata),
    .mem_waitrequest(mem_waitrequest),
    .rfifo_data(rfifo_data), .rfifo_rdreq(b_rfifo_rdreq), .rfifo_rdempty(fifo_empty),
    .cfifo_data(cfifo_data), .cfifo_rdreq(b_cfifo_rdreq), .cfifo_rdempty(fifo_empty),
    .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(b_sc_ready),
    .pass_count(b_pass_count), .fail_count(b_fail_count)
  );

  // Non-showahead FIFO pair model: data appears the cycle after rdreq.
  logic [23:0] res_mem [0:255];
  logic [43:0] chk_mem [0:255];
  int npush = 0;
  int npop  = 0;
  always_comb fifo_empty = (npush == npop);
  always @(posedge clock) begin
    if (a_rfifo_rdreq) begin
      rfifo_data <= res_mem[npop % 256];
      cfifo_data <= chk_mem[npop % 256];
      npop       <= npop + 1;
    end
  end

  // Memory slave: log every accepted write.
  logic [19:0] wa [0:511];
  logic [15:0] wd [0:511];
  int nwr = 0;
  always @(posedge clock) begin
    if (a_mem_write && !mem_waitrequest) begin
      wa[nwr % 512] <= a_mem_address;
      wd[nwr % 512] <= a_mem_writedata;
      nwr           <= nwr + 1;
    end
  end

  // Reference model state.
  logic [19:0] ex_a [0:511];
  logic [15:0] ex_d [0:511];
  int nexp = 0;
  int nchk = 0;
  logic [23:0] mask_m;
  bit          fo_m;
  int pass16, fail16, pass2, fail2;
  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mask_m = 24'hFFFFFF;
    fo_m   = 1'b0;
    pass16 = 0; fail16 = 0; pass2 = 0; fail2 = 0;
  endtask

  task automatic model_vec(input logic [23:0] r, input logic [23:0] e, input logic [19:0] a);
    logic [23:0] rm;
    logic [23:0] em;
    logic        f;
    rm = r & mask_m;
    em = e & mask_m;
    f  = (rm != em);
    if (f) begin
      if (fail16 < 65535) fail16++;
      if (fail2 < 3) fail2++;
    end else begin
      if (pass16 < 65535) pass16++;
      if (pass2 < 3) pass2++;
    end
    if (!(fo_m && !f)) begin
      ex_a[nexp % 512] = a;
      ex_d[nexp % 512] = rm[23:8];
      nexp++;
      ex_a[nexp % 512] = a + 20'd1;
      ex_d[nexp % 512] = {rm[7:0], 1'b1, 6'b0, f};
      nexp++;
    end
  endtask

  task automatic push(input logic [23:0] r, input logic [23:0] e, input logic [19:0] a);
    @(negedge clock);
    res_mem[npush % 256] = r;
    chk_mem[npush % 256] = {e, a};
    npush++;
  endtask

  task automatic cmd(input logic [4:0] c, input logic [23:0] d);
    @(negedge clock);
    sc_cmd  = c;
    sc_data = d;
    @(negedge clock);
    sc_cmd  = 5'd0;
    case (c)
      5'd1: mask_m = d;
      5'd2: fo_m = d[0];
      5'd3: begin pass16 = 0; fail16 = 0; pass2 = 0; fail2 = 0; end
      default: ;
    endcase
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    do begin
      mem_waitrequest = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clock);
      n++;
    end while (!a_sc_ready && n < 200);
    mem_waitrequest = 1'b0;
    chk("idle_timeout", a_sc_ready, 1'b1);
    chk("dut2_ready", b_sc_ready, 1'b1);
  endtask

  task automatic check_all();
    chk("write_count", nwr, nexp);
    for (int i = nchk; i < nexp; i++) begin
      if (i < nwr) begin
        chk("wr_addr", wa[i % 512], ex_a[i % 512]);
        chk("wr_data", wd[i % 512], ex_d[i % 512]);
      end
    end
    nchk = nexp;
    chk("pass_count", a_pass_count, pass16);
    chk("fail_count", a_fail_count, fail16);
    chk("pass_count_w2", b_pass_count, pass2);
    chk("fail_count_w2", b_fail_count, fail2);
  endtask

  task automatic run_vec(input logic [23:0] r, input logic [23:0] e, input logic [19:0] a,
                         input bit rnd);
    model_vec(r, e, a);
    push(r, e, a);
    wait_idle(rnd);
    check_all();
  endtask

  initial begin
    logic [23:0] r;
    logic [23:0] e;
    logic [19:0] a;
    logic [23:0] d;
    int n;

    reset_n = 1'b0;
    mem_waitrequest = 1'b0;
    sc_cmd  = 5'd0;
    sc_data = 24'd0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_mem_write", a_mem_write, 1'b0);
    chk("rst_rdreq", {a_rfifo_rdreq, a_cfifo_rdreq}, 2'b00);
    chk("rst_ready", a_sc_ready, 1'b1);
    chk("rst_counts", {a_pass_count, a_fail_count}, 32'd0);
    chk("byteenable", a_mem_byteenable, 2'b11);
    reset_n = 1'b1;

    // Basic pass, with first-write latency
    model_vec(24'hABCDEF, 24'hABCDEF, 20'h00100);
    push(24'hABCDEF, 24'hABCDEF, 20'h00100);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("lat_early", a_mem_write, 1'b0);
    @(posedge clock);
    @(negedge clock);
    chk("lat_write", a_mem_write, 1'b1);
    chk("lat_addr", a_mem_address, 20'h00100);
    chk("lat_data", a_mem_writedata, 16'hABCD);
    wait_idle(1'b0);
    check_all();

    // Basic fail
    run_vec(24'hABCDEF, 24'hABCDEE, 20'h00200, 1'b0);

    // Fail-only mode
    cmd(5'd3, 24'd0);
    cmd(5'd2, 24'd1);
    run_vec(24'h111111, 24'h111111, 20'h00300, 1'b0);
    run_vec(24'h222222, 24'h222223, 20'h00400, 1'b0);
    cmd(5'd2, 24'd0);

    // Masked compare
    cmd(5'd1, 24'hFFFFF0);
    run_vec(24'h12345F, 24'h123450, 20'h00100, 1'b0);
    cmd(5'd1, 24'hFFFFFF);

    // Stall on word 0: address/data held
    model_vec(24'h5A5A5A, 24'h5A5A5A, 20'h00500);
    mem_waitrequest = 1'b1;
    push(24'h5A5A5A, 24'h5A5A5A, 20'h00500);
    n = 0;
    while (!a_mem_write && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("stall_start", a_mem_write, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("stall_addr", a_mem_address, 20'h00500);
      chk("stall_data", a_mem_writedata, 16'h5A5A);
      @(negedge clock);
    end
    chk("stall_held", {a_mem_write, a_mem_address, a_mem_writedata}, {1'b1, 20'h00500, 16'h5A5A});
    mem_waitrequest = 1'b0;
    wait_idle(1'b0);
    check_all();

    // Address wrap
    run_vec(24'h0F0F0F, 24'h0F0F00, 20'hFFFFF, 1'b0);

    // Reset mid-writeback drops the partial record
    mem_waitrequest = 1'b1;
    push(24'h777777, 24'h777777, 20'h00600);
    n = 0;
    while (!a_mem_write && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("rst_wb_start", a_mem_write, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_wb_drop", a_mem_write, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    mem_waitrequest = 1'b0;
    model_reset();
    check_all();
    run_vec(24'h345678, 24'h345678, 20'h00700, 1'b0);

    // Saturation of the 2-bit counters
    cmd(5'd3, 24'd0);
    for (int k = 0; k < 5; k++) run_vec(24'(k), 24'(k + 1), 20'h00800 + 20'(2 * k), 1'b0);

    // Clear coinciding with the compare cycle
    model_vec(24'hC0FFEE, 24'hC0FFEF, 20'h00900);
    pass16 = 0; fail16 = 0; pass2 = 0; fail2 = 0;
    push(24'hC0FFEE, 24'hC0FFEF, 20'h00900);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    sc_cmd = 5'd3;
    @(negedge clock);
    sc_cmd = 5'd0;
    wait_idle(1'b0);
    check_all();

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          d = $urandom_range(0, 1) ? 24'hFFFFFF : 24'($urandom);
          cmd(5'd1, d);
        end
        1: cmd(5'd2, 24'($urandom));
        2: cmd(5'd3, 24'($urandom));
        3: cmd(5'($urandom_range(4, 31)), 24'($urandom));
        default: ;
      endcase
      r = 24'($urandom);
      e = $urandom_range(0, 1) ? r : (r ^ (24'd1 << $urandom_range(0, 23)));
      a = 20'($urandom);
      run_vec(r, e, a, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
